// File: rtl/cic_interp_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_interp_sequencer_pkg
// Description : Shared constants, state encoding and config helpers for the
//               CIC interpolator sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_interp_sequencer_pkg;

  localparam int CIC_RATE_MAX = 128;
  localparam int CLK_DIV_MIN  = 2;
  localparam int CIC_N        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_t;

  // Legal interpolation ratio is 1..CIC_RATE_MAX; out-of-range requests saturate.
  function automatic logic [7:0] clamp_rate(input logic [7:0] r);
    if (r == 8'd0) return 8'd1;
    if (r > 8'(CIC_RATE_MAX)) return 8'(CIC_RATE_MAX);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : cic_strobe_gen
// Description : Output-rate divider and frame phase counter. tick fires once
//               every clk_div_q enabled cycles; the phase counter advances on
//               each tick and wraps after rate_q ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_strobe_gen
  import cic_interp_sequencer_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] clk_div_q,
  input  logic [7:0]           rate_q,
  output logic                 tick,
  output logic                 frame_start,
  output logic                 frame_end
);

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [7:0]           r_phase;

  assign tick        = en && (r_div_cnt == (clk_div_q - DIV_WIDTH'(1)));
  assign frame_start = tick && (r_phase == 8'd0);
  assign frame_end   = tick && (r_phase == (rate_q - 8'd1));

  // Divider and phase counters; cleared whenever the sequencer is not running.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_div_cnt <= '0;
      r_phase   <= 8'd0;
    end else if (en) begin
      if (tick) begin
        r_div_cnt <= '0;
        r_phase   <= frame_end ? 8'd0 : (r_phase + 8'd1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cic_interp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cic_interp_sequencer
// Description : Strobe scheduler in front of the CIC interpolator. Buffers one
//               upstream sample, issues input/output strobes, and applies
//               config changes only at frame boundaries with a 1-cycle flush.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_interp_sequencer
  import cic_interp_sequencer_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [7:0]           rate,
  input  logic                 cfg_load,
  input  logic [WIDTH-1:0]     src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [WIDTH-1:0]     cic_data_in,
  output logic                 cic_stb_in,
  output logic                 cic_stb_out,
  output logic                 cic_enable,
  output logic [7:0]           cic_rate,
  output logic                 running,
  output logic                 underrun
);

  seq_state_t           r_state;
  seq_state_t           w_state_next;

  logic [DIV_WIDTH-1:0] r_clk_div_q;
  logic [DIV_WIDTH-1:0] r_shadow_div;
  logic [DIV_WIDTH-1:0] w_div_clamped;
  logic [7:0]           r_rate_q;
  logic [7:0]           r_shadow_rate;
  logic [7:0]           w_rate_clamped;
  logic                 r_pending;
  logic                 r_full;
  logic [WIDTH-1:0]     r_buf;
  logic                 r_underrun;

  logic                 w_tick;
  logic                 w_frame_start;
  logic                 w_frame_end;
  logic                 w_run;
  logic                 w_run_en;
  logic                 w_consume;
  logic                 w_apply;
  logic                 w_xfer;

  assign w_div_clamped  = (clk_div < DIV_WIDTH'(CLK_DIV_MIN)) ? DIV_WIDTH'(CLK_DIV_MIN) : clk_div;
  assign w_rate_clamped = clamp_rate(rate);

  assign w_run     = (r_state == ST_RUN);
  assign w_run_en  = w_run && enable;
  // frame_start is only produced while running, so it is exactly the consume event.
  assign w_consume = w_frame_start;
  assign w_apply   = w_frame_end && r_pending;
  assign w_xfer    = src_valid && src_ready;

  assign cic_data_in = r_buf;
  assign cic_rate    = r_rate_q;
  assign running     = w_run;
  assign underrun    = r_underrun;

  cic_strobe_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_strobe_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (!w_run),
    .en          (w_run),
    .clk_div_q   (r_clk_div_q),
    .rate_q      (r_rate_q),
    .tick        (w_tick),
    .frame_start (w_frame_start),
    .frame_end   (w_frame_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and per-state control outputs; dropping enable always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    src_ready    = 1'b0;
    cic_enable   = 1'b0;
    cic_stb_out  = 1'b0;
    cic_stb_in   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_PRIME;
      end
      ST_PRIME: begin
        cic_enable = 1'b1;
        src_ready  = !r_full;
        if (r_full) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        cic_enable  = 1'b1;
        src_ready   = !r_full || w_consume;
        cic_stb_out = w_tick;
        cic_stb_in  = w_consume;
        if (w_apply) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        src_ready    = !r_full;
        w_state_next = ST_PRIME;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (!enable) begin
      w_state_next = ST_IDLE;
      src_ready    = 1'b0;
    end
  end

  // One-entry sample buffer; an empty buffer reads as zero so an underrun strobe carries 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end else if (!enable) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end else if (w_xfer) begin
      r_full <= 1'b1;
      r_buf  <= src_data;
    end else if (w_consume) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end
  end

  // Sticky underrun; a new underrun event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                          r_underrun <= 1'b0;
    else if (w_consume && !r_full)    r_underrun <= 1'b1;
    else if (cfg_load)                r_underrun <= 1'b0;
  end

  // Active and shadow configuration. Outside RUN a load applies directly;
  // inside RUN it waits in the shadow until the frame-end tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_div_q   <= DIV_WIDTH'(CLK_DIV_MIN);
      r_rate_q      <= 8'd1;
      r_shadow_div  <= DIV_WIDTH'(CLK_DIV_MIN);
      r_shadow_rate <= 8'd1;
      r_pending     <= 1'b0;
    end else if (!w_run_en) begin
      r_pending <= 1'b0;
      if (cfg_load) begin
        r_clk_div_q <= w_div_clamped;
        r_rate_q    <= w_rate_clamped;
      end
    end else if (w_apply) begin
      r_clk_div_q <= cfg_load ? w_div_clamped  : r_shadow_div;
      r_rate_q    <= cfg_load ? w_rate_clamped : r_shadow_rate;
      r_pending   <= 1'b0;
    end else if (cfg_load) begin
      r_shadow_div  <= w_div_clamped;
      r_shadow_rate <= w_rate_clamped;
      r_pending     <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_interp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_interp_sequencer
// Description : Self-checking bench for cic_interp_sequencer: per-cycle
//               behavioural model plus directed scenarios with literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_interp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] clk_div;
  logic [7:0]  rate;
  logic        cfg_load;
  logic [15:0] src_data = 16'h0100;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] cic_data_in;
  logic        cic_stb_in;
  logic        cic_stb_out;
  logic        cic_enable;
  logic [7:0]  cic_rate;
  logic        running;
  logic        underrun;

  int n_chk = 0;
  int n_err = 0;

  cic_interp_sequencer #(
    .WIDTH     (16),
    .DIV_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clk_div     (clk_div),
    .rate        (rate),
    .cfg_load    (cfg_load),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .cic_data_in (cic_data_in),
    .cic_stb_in  (cic_stb_in),
    .cic_stb_out (cic_stb_out),
    .cic_enable  (cic_enable),
    .cic_rate    (cic_rate),
    .running     (running),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Upstream source: a new sample (previous + 1) is presented after every accepted transfer.
  always begin : feeder
    logic x;
    @(negedge clk);
    x = src_valid && src_ready;
    @(posedge clk);
    #1;
    if (x) src_data = src_data + 16'd1;
  end

  // Strobe statistics measured from the DUT outputs.
  int          cyc = 0;
  int          run_k = 0;
  int          first_k = -1;
  int          n_out = 0, n_in = 0, n_zero = 0, n_order = 0;
  int          last_out = 0, out_gap = 0, last_in = 0, in_gap = 0;
  logic [15:0] prev_data = 16'd0;
  logic        have_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (running) begin
      if (cic_stb_out) begin
        n_out++;
        out_gap  = cyc - last_out;
        last_out = cyc;
        if (first_k < 0) first_k = run_k;
      end
      if (cic_stb_in) begin
        n_in++;
        in_gap  = cyc - last_in;
        last_in = cyc;
        if (cic_data_in == 16'd0) n_zero++;
        if (have_prev && cic_data_in != 16'd0 && cic_data_in != prev_data + 16'd1) n_order++;
        prev_data = cic_data_in;
        have_prev = (cic_data_in != 16'd0);
      end
      run_k++;
    end else begin
      run_k   = 0;
      first_k = -1;
    end
    if (!cic_enable) have_prev = 1'b0;
  end

  // Behavioural model: strobe timing from RUN-relative cycle count arithmetic.
  // Compared on every falling edge, then advanced to the state after the next rising edge.
  logic        m_valid = 1'b0;
  int          m_mode = 0;  // 0 idle, 1 prime, 2 run, 3 flush
  int          m_k = 0, m_div = 2, m_rate = 1, m_sdiv = 2, m_srate = 1;
  logic        m_full = 1'b0, m_pend = 1'b0, m_under = 1'b0;
  logic [15:0] m_data = 16'd0;

  always @(negedge clk) begin : model_cmp
    logic run, e_tick, e_in, e_fend, e_ready, xfer, old_full, old_pend;
    int t, cd, cr, old_mode;
    logic [15:0] e_data;
    run     = (m_mode == 2);
    e_tick  = run && (((m_k + 1) % m_div) == 0);
    t       = (m_k + 1) / m_div;
    e_in    = e_tick && (((t - 1) % m_rate) == 0);
    e_fend  = e_tick && ((t % m_rate) == 0);
    e_ready = enable && (m_mode != 0) && (!m_full || e_in);
    e_data  = m_full ? m_data : 16'd0;
    if (m_valid) begin
      chk("running",     32'(running),     32'(run));
      chk("cic_enable",  32'(cic_enable),  32'(m_mode == 1 || m_mode == 2));
      chk("cic_stb_out", 32'(cic_stb_out), 32'(e_tick));
      chk("cic_stb_in",  32'(cic_stb_in),  32'(e_in));
      chk("src_ready",   32'(src_ready),   32'(e_ready));
      chk("cic_data_in", 32'(cic_data_in), 32'(e_data));
      chk("cic_rate",    32'(cic_rate),    32'(m_rate));
      chk("underrun",    32'(underrun),    32'(m_under));
    end
    if (rst) begin
      m_valid = 1'b1; m_mode = 0; m_k = 0; m_full = 1'b0; m_data = 16'd0;
      m_div = 2; m_rate = 1; m_sdiv = 2; m_srate = 1; m_pend = 1'b0; m_under = 1'b0;
    end else begin
      cd       = (clk_div < 16'd2) ? 2 : int'(clk_div);
      cr       = (rate == 8'd0) ? 1 : ((rate > 8'd128) ? 128 : int'(rate));
      old_full = m_full;
      old_pend = m_pend;
      old_mode = m_mode;
      xfer     = src_valid && e_ready;
      if (!enable) begin
        m_full = 1'b0; m_data = 16'd0; m_pend = 1'b0;
      end else if (xfer) begin
        m_full = 1'b1; m_data = src_data;
      end else if (e_in) begin
        m_full = 1'b0; m_data = 16'd0;
      end
      if (e_in && !old_full) m_under = 1'b1;
      else if (cfg_load)     m_under = 1'b0;
      if (!(run && enable)) begin
        if (cfg_load) begin m_div = cd; m_rate = cr; end
      end else if (e_fend && old_pend) begin
        m_div  = cfg_load ? cd : m_sdiv;
        m_rate = cfg_load ? cr : m_srate;
        m_pend = 1'b0;
      end else if (cfg_load) begin
        m_sdiv = cd; m_srate = cr; m_pend = 1'b1;
      end
      if (!enable) m_mode = 0;
      else if (old_mode == 0) m_mode = 1;
      else if (old_mode == 1) m_mode = old_full ? 2 : 1;
      else if (old_mode == 2) m_mode = (e_fend && old_pend) ? 3 : 2;
      else m_mode = 1;
      m_k = (old_mode == 2 && m_mode == 2) ? m_k + 1 : 0;
    end
  end

  task automatic wait_running(input logic exp);
    int i = 0;
    while (running !== exp && i < 50) begin
      tick(1);
      i++;
    end
    chk("wait_running", 32'(running), 32'(exp));
  endtask

  task automatic wait_stb_in();
    int n0 = n_in;
    int i  = 0;
    while (n_in == n0 && i < 400) begin
      tick(1);
      i++;
    end
    chk("wait_stb_in", 32'(n_in != n0), 32'd1);
  endtask

  task automatic load_cfg(input logic [15:0] d, input logic [7:0] r);
    clk_div  = d;
    rate     = r;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  initial begin : stim
    int s_out, s_in, s_zero, s_order;
    rst = 1'b1; enable = 1'b0; clk_div = 16'd4; rate = 8'd8; cfg_load = 1'b0; src_valid = 1'b0;
    tick(3);
    chk("rst_cic_rate", 32'(cic_rate), 32'd1);
    chk("rst_running",  32'(running),  32'd0);
    chk("rst_data",     32'(cic_data_in), 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: clk_div=4, rate=8, source always valid
    load_cfg(16'd4, 8'd8);
    src_valid = 1'b1;
    enable    = 1'b1;
    wait_running(1'b1);
    s_out = n_out; s_in = n_in;
    tick(96);
    chk("t1_first_strobe_k", 32'(first_k), 32'd3);
    chk("t1_n_stb_out", 32'(n_out - s_out), 32'd24);
    chk("t1_n_stb_in",  32'(n_in - s_in),   32'd3);
    chk("t1_out_gap",   32'(out_gap), 32'd4);
    chk("t1_in_gap",    32'(in_gap),  32'd32);
    chk("t1_underrun",  32'(underrun), 32'd0);
    chk("t1_cic_rate",  32'(cic_rate), 32'd8);

    // 2: source stalls long enough for one empty-buffer strobe
    wait_stb_in();
    tick(31);
    s_zero = n_zero;
    src_valid = 1'b0;
    tick(40);
    src_valid = 1'b1;
    chk("t2_zero_strobes", 32'(n_zero - s_zero), 32'd1);
    chk("t2_underrun", 32'(underrun), 32'd1);
    load_cfg(16'd4, 8'd8);
    chk("t2_underrun_cleared", 32'(underrun), 32'd0);
    tick(80);

    // 3: rate change requested at phase 3 of 8
    wait_stb_in();
    tick(13);
    load_cfg(16'd4, 8'd4);
    tick(12);
    chk("t3_rate_held", 32'(cic_rate), 32'd8);
    chk("t3_still_run", 32'(running),  32'd1);
    tick(2);
    chk("t3_flush_en",   32'(cic_enable), 32'd0);
    chk("t3_flush_rate", 32'(cic_rate),   32'd4);
    tick(1);
    chk("t3_prime_en",   32'(cic_enable), 32'd1);
    chk("t3_prime_run",  32'(running),    32'd0);
    tick(1);
    chk("t3_rerun", 32'(running), 32'd1);
    tick(40);
    chk("t3_in_gap", 32'(in_gap), 32'd16);

    // 4: boundary config values
    enable = 1'b0;
    tick(2);
    load_cfg(16'd1, 8'd0);
    chk("t4_rate_min", 32'(cic_rate), 32'd1);
    enable = 1'b1;
    wait_running(1'b1);
    tick(20);
    chk("t4_out_gap", 32'(out_gap), 32'd2);
    chk("t4_in_gap",  32'(in_gap),  32'd2);
    load_cfg(16'd1, 8'd200);
    tick(20);
    chk("t4_rate_max",   32'(cic_rate), 32'd128);
    chk("t4_out_gap128", 32'(out_gap),  32'd2);
    chk("t4_running",    32'(running),  32'd1);

    // 5: reset mid-run, then disable mid-run
    rst = 1'b1;
    tick(1);
    chk("t5_rst_rate",    32'(cic_rate),    32'd1);
    chk("t5_rst_enable",  32'(cic_enable),  32'd0);
    chk("t5_rst_ready",   32'(src_ready),   32'd0);
    chk("t5_rst_data",    32'(cic_data_in), 32'd0);
    chk("t5_rst_running", 32'(running),     32'd0);
    enable = 1'b0;
    rst    = 1'b0;
    tick(2);
    load_cfg(16'd3, 8'd8);
    enable = 1'b1;
    wait_running(1'b1);
    tick(10);
    enable = 1'b0;
    tick(1);
    chk("t5_dis_running", 32'(running),     32'd0);
    chk("t5_dis_enable",  32'(cic_enable),  32'd0);
    chk("t5_dis_ready",   32'(src_ready),   32'd0);
    chk("t5_dis_data",    32'(cic_data_in), 32'd0);
    chk("t5_dis_rate",    32'(cic_rate),    32'd8);

    // 6: back-to-back consume and refill
    tick(1);
    load_cfg(16'd2, 8'd1);
    enable = 1'b1;
    wait_running(1'b1);
    s_in = n_in; s_order = n_order; s_zero = n_zero;
    tick(60);
    chk("t6_n_stb_in", 32'(n_in - s_in),       32'd30);
    chk("t6_order",    32'(n_order - s_order), 32'd0);
    chk("t6_no_zero",  32'(n_zero - s_zero),   32'd0);
    chk("t6_underrun", 32'(underrun),          32'd0);

    enable = 1'b0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
